fault_counters: RTL and testbench
=================================

Name: fault_counters

Overview:
- CAN error-counter unit: maintains the receive error counter (REC), transmit error counter (TEC) and bus-off recovery counter (ERB).
- Produces the threshold flags consumed by the fault confinement state machine: rec_lt96/ge96/ge128, tec_lt96/ge96/ge128/ge256, erb_eq128.
- Consumes that state machine's busoff and resetcount outputs, closing the loop between bit-level error detection and fault confinement.

Parameters:
- WARN_LIMIT, 96, warning threshold for REC/TEC.
- PASSIVE_LIMIT, 128, error-passive threshold for REC/TEC.
- BUSOFF_LIMIT, 256, TEC bus-off threshold and saturation value.
- ERB_LIMIT, 128, number of 11-recessive-bit sequences needed for bus-off recovery.
- REC_RELOAD, 119, REC value loaded on a successful reception while REC > 127.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low; clock clock.
- resetcount  in  1  active-low synchronous clear of all counters (driven by the fault FSM).
- busoff  in  1  fault FSM is in bus-off; enables ERB counting.
- rx_err_inc1  in  1  pulse: receive error, REC +1.
- rx_err_inc8  in  1  pulse: dominant bit after error flag, REC +8.
- rx_ok_dec  in  1  pulse: successful reception.
- tx_err_inc8  in  1  pulse: transmit error, TEC +8.
- tx_ok_dec  in  1  pulse: successful transmission, TEC -1.
- rec11_seen  in  1  pulse: 11 consecutive recessive bits detected.
- rec_lt96, rec_ge96, rec_ge128  out  1 each  REC threshold flags.
- tec_lt96, tec_ge96, tec_ge128, tec_ge256  out  1 each  TEC threshold flags.
- erb_eq128  out  1  ERB == ERB_LIMIT.

Behaviour:
- Counter widths: REC 8 bit, TEC 9 bit, ERB 8 bit, all registered.
- Reset (reset==0) or resetcount==0 clears REC, TEC and ERB to 0 on the next edge. Flags after clear: rec_lt96=1, tec_lt96=1, all others 0.
- Flags are combinational compares of the registered counters, so they update one cycle after the event edge.
- lt96 is the exact complement of ge96 for each counter.
- REC per cycle, priority inc8 > inc1 > dec; only one action is applied per cycle:
  - inc8: REC = min(REC+8, 255).
  - inc1: REC = min(REC+1, 255).
  - dec: if REC > 127, REC = REC_RELOAD; else if REC > 0, REC = REC-1; at 0, hold.
- TEC per cycle, priority inc8 > dec; independent of REC, so simultaneous REC and TEC events are both applied:
  - inc8: TEC = min(TEC+8, BUSOFF_LIMIT).
  - dec: if TEC > 0, TEC = TEC-1; at 0, hold.
  - REC and TEC freeze while busoff==1; event pulses are ignored.
- ERB:
  - Increments on rec11_seen only while busoff==1.
  - Saturates at ERB_LIMIT.
  - Holds at 0 while busoff==0.
  - Cleared together with REC and TEC by resetcount==0. The FSM's reset state pulses resetcount low, restoring the error-active counts.
- ge-comparisons are >=: REC=96 gives rec_ge96=1; TEC=256 gives tec_ge256=1.
- Reset mid-operation overrides every event input in that cycle.

Optional Feature:
- Macro: FAULTCNT_READBACK_EN.
- Defined: adds outputs rec_value[7:0], tec_value[8:0] and erb_value[7:0], mirroring the registered counters for the status register (REC and TEC saturation readable; TEC shown as 256 in bus-off).
- Undefined: these ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fault_pkg holds:
  - the threshold constants (96, 128, 256, ERB limit, REC reload);
  - the counter widths;
  - the fault-state encodings shared with the fault FSM.
- One natural sub-module, sat_counter: a parameterised width/max up-down counter with +1, +8, -1, load and clear. It is instantiated for TEC and ERB; REC uses its load port for REC_RELOAD.

Test Plan:
- Reset, then 12 tx_err_inc8 pulses -> TEC=96, tec_ge96=1 and tec_lt96=0 one cycle after the 12th pulse; rec_lt96=1.
- REC=127, one rx_err_inc1 -> REC=128, rec_ge128=1; then rx_ok_dec -> REC=119, rec_ge128=0, rec_ge96=1.
- 32 tx_err_inc8 pulses -> TEC=256, tec_ge256=1; with busoff=1, 128 rec11_seen pulses -> erb_eq128=1; a 129th pulse holds ERB at 128.
- Same cycle rx_err_inc8, rx_err_inc1 and tx_ok_dec with REC=0, TEC=5 -> REC=8 (inc1 ignored), TEC=4.
- REC=200, TEC=150, pulse resetcount=0 for one cycle -> REC=0, TEC=0, ERB=0; rec_lt96=1, tec_lt96=1.
- rx_ok_dec and tx_ok_dec at REC=0, TEC=0 -> both counters stay 0 (no wrap); rec11_seen with busoff=0 -> ERB stays 0.

Source files
------------

// File: rtl/fault_pkg.sv
// Shared constants for the CAN fault-confinement counters and FSM.
package fault_pkg;

    localparam int WARN_LIMIT    = 96;
    localparam int PASSIVE_LIMIT = 128;
    localparam int BUSOFF_LIMIT  = 256;
    localparam int ERB_LIMIT     = 128;
    localparam int REC_RELOAD    = 119;

    localparam int REC_W = 8;
    localparam int TEC_W = 9;
    localparam int ERB_W = 8;

    typedef enum logic [1:0] {
        ERR_ACTIVE  = 2'd0,
        ERR_PASSIVE = 2'd1,
        BUS_OFF     = 2'd2
    } fault_state_e;

endpackage

// File: rtl/fault_counters_if.sv
// Event/flag bundle between error detection, fault FSM and counters.
// FAULTCNT_READBACK_EN adds counter value mirrors for status readback.
interface fault_counters_if;

    logic resetcount;
    logic busoff;
    logic rx_err_inc1;
    logic rx_err_inc8;
    logic rx_ok_dec;
    logic tx_err_inc8;
    logic tx_ok_dec;
    logic rec11_seen;
    logic rec_lt96;
    logic rec_ge96;
    logic rec_ge128;
    logic tec_lt96;
    logic tec_ge96;
    logic tec_ge128;
    logic tec_ge256;
    logic erb_eq128;
`ifdef FAULTCNT_READBACK_EN
    logic [fault_pkg::REC_W-1:0] rec_value;
    logic [fault_pkg::TEC_W-1:0] tec_value;
    logic [fault_pkg::ERB_W-1:0] erb_value;
`endif

    modport master (
        output resetcount, busoff, rx_err_inc1, rx_err_inc8,
        output rx_ok_dec, tx_err_inc8, tx_ok_dec, rec11_seen,
        input  rec_lt96, rec_ge96, rec_ge128,
        input  tec_lt96, tec_ge96, tec_ge128, tec_ge256, erb_eq128
`ifdef FAULTCNT_READBACK_EN
        , input rec_value, tec_value, erb_value
`endif
    );

    modport slave (
        input  resetcount, busoff, rx_err_inc1, rx_err_inc8,
        input  rx_ok_dec, tx_err_inc8, tx_ok_dec, rec11_seen,
        output rec_lt96, rec_ge96, rec_ge128,
        output tec_lt96, tec_ge96, tec_ge128, tec_ge256, erb_eq128
`ifdef FAULTCNT_READBACK_EN
        , output rec_value, tec_value, erb_value
`endif
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter: clear > +8 > +1 > load > -1, floor at 0.
module sat_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc8,
    input  logic         inc1,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] q
);

    localparam logic [W:0] MAXV = (W+1)'(MAX);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W:0]   sum8, sum1;

    always_comb begin
        sum8  = {1'b0, cnt_q} + (W+1)'(8);
        sum1  = {1'b0, cnt_q} + (W+1)'(1);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc8) begin
            cnt_d = (sum8 > MAXV) ? MAXV[W-1:0] : sum8[W-1:0];
        end else if (inc1) begin
            cnt_d = (sum1 > MAXV) ? MAXV[W-1:0] : sum1[W-1:0];
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/fault_counters.sv
// CAN REC/TEC/ERB error counters and fault-confinement threshold flags.
// FAULTCNT_READBACK_EN exposes the raw counter values on the bus.
module fault_counters
    import fault_pkg::*;
(
    input logic             clock,
    input logic             reset,
    fault_counters_if.slave bus
);

    localparam logic [REC_W-1:0] REC_WARN = REC_W'(WARN_LIMIT);
    localparam logic [REC_W-1:0] REC_PASV = REC_W'(PASSIVE_LIMIT);
    localparam logic [TEC_W-1:0] TEC_WARN = TEC_W'(WARN_LIMIT);
    localparam logic [TEC_W-1:0] TEC_PASV = TEC_W'(PASSIVE_LIMIT);
    localparam logic [TEC_W-1:0] TEC_BOFF = TEC_W'(BUSOFF_LIMIT);
    localparam logic [ERB_W-1:0] ERB_MAX  = ERB_W'(ERB_LIMIT);

    logic             clr;
    logic             run;
    logic [REC_W-1:0] rec;
    logic [TEC_W-1:0] tec;
    logic [ERB_W-1:0] erb;

    assign clr = ~bus.resetcount;
    assign run = ~bus.busoff;

    // Success above the passive limit snaps REC back to the reload value.
    sat_counter #(.W(REC_W), .MAX(255)) u_rec (
        .clock    (clock),
        .reset    (reset),
        .clr      (clr),
        .inc8     (run & bus.rx_err_inc8),
        .inc1     (run & bus.rx_err_inc1),
        .load     (run & bus.rx_ok_dec & (rec >= REC_PASV)),
        .dec      (run & bus.rx_ok_dec),
        .load_val (REC_W'(REC_RELOAD)),
        .q        (rec)
    );

    sat_counter #(.W(TEC_W), .MAX(BUSOFF_LIMIT)) u_tec (
        .clock    (clock),
        .reset    (reset),
        .clr      (clr),
        .inc8     (run & bus.tx_err_inc8),
        .inc1     (1'b0),
        .load     (1'b0),
        .dec      (run & bus.tx_ok_dec),
        .load_val ('0),
        .q        (tec)
    );

    // Recovery count only lives while bus-off; otherwise pinned at zero.
    sat_counter #(.W(ERB_W), .MAX(ERB_LIMIT)) u_erb (
        .clock    (clock),
        .reset    (reset),
        .clr      (clr | run),
        .inc8     (1'b0),
        .inc1     (bus.rec11_seen),
        .load     (1'b0),
        .dec      (1'b0),
        .load_val ('0),
        .q        (erb)
    );

    assign bus.rec_ge96  = rec >= REC_WARN;
    assign bus.rec_lt96  = ~bus.rec_ge96;
    assign bus.rec_ge128 = rec >= REC_PASV;
    assign bus.tec_ge96  = tec >= TEC_WARN;
    assign bus.tec_lt96  = ~bus.tec_ge96;
    assign bus.tec_ge128 = tec >= TEC_PASV;
    assign bus.tec_ge256 = tec >= TEC_BOFF;
    assign bus.erb_eq128 = erb == ERB_MAX;

`ifdef FAULTCNT_READBACK_EN
    assign bus.rec_value = rec;
    assign bus.tec_value = tec;
    assign bus.erb_value = erb;
`endif

endmodule

// File: tb/tb_fault_counters.sv
// Scoreboard bench for fault_counters: directed pulses, queued expectations.
module tb_fault_counters;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    fault_counters_if bus();

    fault_counters dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string name;
        int    rec;
        int    tec;
        int    erb;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam bit [5:0] RX8  = 6'b100000;
    localparam bit [5:0] RX1  = 6'b010000;
    localparam bit [5:0] RXOK = 6'b001000;
    localparam bit [5:0] TX8  = 6'b000100;
    localparam bit [5:0] TXOK = 6'b000010;
    localparam bit [5:0] R11  = 6'b000001;

    function automatic logic [7:0] flags_of(input int r, input int t,
                                            input int e);
        return {r < 96, r >= 96, r >= 128,
                t < 96, t >= 96, t >= 128, t >= 256, e == 128};
    endfunction

    function automatic logic [7:0] dut_flags();
        return {bus.rec_lt96, bus.rec_ge96, bus.rec_ge128,
                bus.tec_lt96, bus.tec_ge96, bus.tec_ge128,
                bus.tec_ge256, bus.erb_eq128};
    endfunction

    task automatic drive(input bit [5:0] e);
        bus.rx_err_inc8 = e[5];
        bus.rx_err_inc1 = e[4];
        bus.rx_ok_dec   = e[3];
        bus.tx_err_inc8 = e[2];
        bus.tx_ok_dec   = e[1];
        bus.rec11_seen  = e[0];
    endtask

    task automatic pulse(input bit [5:0] e, input int n);
        repeat (n) begin
            @(negedge clock);
            drive(e);
            @(posedge clock);
            #1;
            drive(6'b0);
        end
    endtask

    task automatic rc_pulse();
        @(negedge clock);
        bus.resetcount = 1'b0;
        @(posedge clock);
        #1;
        bus.resetcount = 1'b1;
    endtask

    task automatic rst_pulse(input bit [5:0] e);
        @(negedge clock);
        reset = 1'b0;
        drive(e);
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(6'b0);
    endtask

    task automatic set_busoff(input logic v);
        @(negedge clock);
        bus.busoff = v;
    endtask

    task automatic chk(input string nm, input int r, input int t,
                       input int e);
        sb.push_back('{name: nm, rec: r, tec: t, erb: e});
    endtask

    // Monitor: one expectation is consumed per cycle away from the edge.
    initial begin
        forever begin
            @(negedge clock);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                n_chk++;
                if (dut_flags() !== flags_of(cur.rec, cur.tec, cur.erb)) begin
                    n_fail++;
                    $display("FAIL %s flags got %b expected %b", cur.name,
                             dut_flags(), flags_of(cur.rec, cur.tec, cur.erb));
                end
`ifdef FAULTCNT_READBACK_EN
                n_chk++;
                if (bus.rec_value !== 8'(cur.rec) ||
                    bus.tec_value !== 9'(cur.tec) ||
                    bus.erb_value !== 8'(cur.erb)) begin
                    n_fail++;
                    $display("FAIL %s values got %0d/%0d/%0d expected %0d/%0d/%0d",
                             cur.name, bus.rec_value, bus.tec_value,
                             bus.erb_value, cur.rec, cur.tec, cur.erb);
                end
`endif
            end
        end
    end

    initial begin
        reset = 1'b0;
        drive(6'b0);
        bus.resetcount = 1'b1;
        bus.busoff     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset", 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;

        pulse(TX8, 11);  chk("tec88", 0, 88, 0);
        pulse(TX8, 1);   chk("tec96", 0, 96, 0);
        rc_pulse();      chk("clr_a", 0, 0, 0);

        pulse(RX8, 11);
        pulse(RX1, 7);   chk("rec95", 95, 0, 0);
        pulse(RX1, 1);   chk("rec96", 96, 0, 0);
        pulse(RX1, 31);  chk("rec127", 127, 0, 0);
        pulse(RX1, 1);   chk("rec128", 128, 0, 0);
        pulse(RXOK, 1);  chk("rec_reload", 119, 0, 0);
        pulse(RXOK, 23); chk("rec_dec96", 96, 0, 0);
        pulse(RXOK, 1);  chk("rec_dec95", 95, 0, 0);
        pulse(RX8, 20);  chk("rec255", 255, 0, 0);
        pulse(RX8, 1);   chk("rec_sat8", 255, 0, 0);
        pulse(RX1, 1);   chk("rec_sat1", 255, 0, 0);
        pulse(RXOK, 1);  chk("rec_sat_reload", 119, 0, 0);
        rc_pulse();      chk("clr_b", 0, 0, 0);

        pulse(TX8, 1);
        pulse(TXOK, 3);  chk("tec5", 0, 5, 0);
        pulse(RX8 | RX1 | TXOK, 1); chk("same_cycle", 8, 4, 0);
        pulse(RX8, 10);
        pulse(RX1, 7);   chk("same_rec_probe", 95, 4, 0);
        pulse(TX8, 12);
        pulse(TXOK, 4);  chk("same_tec_probe96", 95, 96, 0);
        pulse(TXOK, 1);  chk("same_tec_probe95", 95, 95, 0);
        rc_pulse();      chk("clr_c", 0, 0, 0);

        pulse(RXOK | TXOK, 3); chk("no_wrap", 0, 0, 0);
        pulse(R11, 5);   chk("erb_idle", 0, 0, 0);

        pulse(TX8, 31);  chk("tec248", 0, 248, 0);
        pulse(TX8, 1);   chk("tec256", 0, 256, 0);
        pulse(TX8, 1);   chk("tec_sat", 0, 256, 0);
        set_busoff(1'b1);
        pulse(RX8 | RX1 | RXOK | TX8 | TXOK, 13); chk("freeze", 0, 256, 0);
        pulse(R11, 127); chk("erb127", 0, 256, 127);
        pulse(R11, 1);   chk("erb128", 0, 256, 128);
        pulse(R11, 1);   chk("erb_sat", 0, 256, 128);
        rc_pulse();      chk("clr_busoff", 0, 0, 0);
        set_busoff(1'b0);

        pulse(RX8 | TX8, 18);
        pulse(RX8, 7);
        pulse(TX8, 1);
        pulse(TXOK, 2);  chk("rec200_tec150", 200, 150, 0);
        rc_pulse();      chk("clr_d", 0, 0, 0);

        pulse(TX8, 5);
        rst_pulse(TX8 | RX8); chk("reset_override", 0, 0, 0);
        pulse(TX8, 11);  chk("post_reset88", 0, 88, 0);
        pulse(TX8, 1);   chk("post_reset96", 0, 96, 0);

        repeat (3) @(posedge clock);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0",
                     sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
